// File: rtl/run_ctrl_pkg.sv
// Shared types and defaults for the core run controller.
package run_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HOLD,
    RELEASE,
    RUN,
    DONE,
    TIMEOUT
  } run_state_t;

  localparam int DEF_NUM_DOMAINS    = 2;
  localparam int DEF_HOLD_CYCLES    = 2;
  localparam int DEF_STAGGER_CYCLES = 1;
  localparam int DEF_MAX_CYCLES     = 100;
  localparam int DEF_CNT_W          = 32;
  localparam int DEF_AUTO_START     = 1;

  // Edge offset after E0 at which domain idx leaves reset.
  function automatic int release_offset(input int idx, input int hold, input int stagger);
    return hold + idx * stagger;
  endfunction

endpackage

// File: rtl/core_run_controller.sv
// Run controller: holds reset domains, releases them staggered, counts run
// cycles, ends on halt or watchdog, supports re-run and abort.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | all domains in reset, waiting for start (or first auto start)
// HOLD    | run launched, no domain released yet
// RELEASE | some but not all domains released
// RUN     | all domains released, cycle_count advancing
// DONE    | run ended by halt_req, domains back in reset, done sticky
// TIMEOUT | run ended by watchdog, domains back in reset, timeout sticky
module core_run_controller
  import run_ctrl_pkg::*;
#(
  parameter int NUM_DOMAINS    = DEF_NUM_DOMAINS,
  parameter int HOLD_CYCLES    = DEF_HOLD_CYCLES,
  parameter int STAGGER_CYCLES = DEF_STAGGER_CYCLES,
  parameter int MAX_CYCLES     = DEF_MAX_CYCLES,
  parameter int CNT_W          = DEF_CNT_W,
  parameter int AUTO_START     = DEF_AUTO_START
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   halt_req,
  output logic [NUM_DOMAINS-1:0] dom_reset,
  output logic                   running,
  output logic                   done,
  output logic                   timeout,
  output logic [CNT_W-1:0]       cycle_count
);

  // Phase counter only has to reach the last domain's release offset.
  localparam int LAST_OFF = release_offset(NUM_DOMAINS - 1, HOLD_CYCLES, STAGGER_CYCLES);
  localparam int PH_W     = (LAST_OFF < 1) ? 1 : $clog2(LAST_OFF + 1);
  localparam int REL_W    = $clog2(NUM_DOMAINS + 1);

  run_state_t             state_q, state_d;
  logic [PH_W-1:0]        ph_q, ph_d;
  logic [REL_W-1:0]       rel_q, rel_d;
  logic                   auto_fired_q, auto_fired_d;
  logic [NUM_DOMAINS-1:0] dom_d;
  logic                   run_d, done_d, to_d;
  logic [CNT_W-1:0]       cnt_d;
  logic                   auto_go;

  // Auto start fires only on the very first edge after global reset.
  assign auto_go = (AUTO_START != 0) && !auto_fired_q;

  // Next-state and next-output logic; abort overrides everything.
  always_comb begin
    state_d      = state_q;
    ph_d         = ph_q;
    rel_d        = rel_q;
    auto_fired_d = 1'b1;
    dom_d        = dom_reset;
    run_d        = running;
    done_d       = done;
    to_d         = timeout;
    cnt_d        = cycle_count;

    if (abort) begin
      state_d = IDLE;
      ph_d    = '0;
      rel_d   = '0;
      dom_d   = '1;
      run_d   = 1'b0;
      done_d  = 1'b0;
      to_d    = 1'b0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE, DONE, TIMEOUT: begin
          if (start || (state_q == IDLE && auto_go)) begin
            state_d = HOLD;
            ph_d    = '0;
            rel_d   = '0;
            dom_d   = '1;
            run_d   = 1'b0;
            done_d  = 1'b0;
            to_d    = 1'b0;
            cnt_d   = '0;
          end
        end
        HOLD, RELEASE: begin
          ph_d = ph_q + PH_W'(1);
          // ph_q+1 is the number of edges since E0 at this edge.
          for (int i = 0; i < NUM_DOMAINS; i++) begin
            if (i >= int'(rel_q) &&
                release_offset(i, HOLD_CYCLES, STAGGER_CYCLES) <= int'(ph_q) + 1) begin
              dom_d[i] = 1'b0;
              rel_d    = rel_d + REL_W'(1);
            end
          end
          if (rel_d == REL_W'(NUM_DOMAINS)) begin
            state_d = RUN;
            ph_d    = '0;
            run_d   = 1'b1;
            cnt_d   = '0;
          end else if (rel_d != '0) begin
            state_d = RELEASE;
          end else begin
            state_d = HOLD;
          end
        end
        RUN: begin
          if (halt_req) begin
            state_d = DONE;
            done_d  = 1'b1;
            run_d   = 1'b0;
            dom_d   = '1;
          end else if (MAX_CYCLES != 0 && cycle_count == CNT_W'(MAX_CYCLES - 1)) begin
            state_d = TIMEOUT;
            to_d    = 1'b1;
            run_d   = 1'b0;
            dom_d   = '1;
            cnt_d   = CNT_W'(MAX_CYCLES);
          end else if (cycle_count != '1) begin
            cnt_d = cycle_count + CNT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          dom_d   = '1;
          run_d   = 1'b0;
        end
      endcase
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      ph_q         <= '0;
      rel_q        <= '0;
      auto_fired_q <= 1'b0;
      dom_reset    <= '1;
      running      <= 1'b0;
      done         <= 1'b0;
      timeout      <= 1'b0;
      cycle_count  <= '0;
    end else begin
      state_q      <= state_d;
      ph_q         <= ph_d;
      rel_q        <= rel_d;
      auto_fired_q <= auto_fired_d;
      dom_reset    <= dom_d;
      running      <= run_d;
      done         <= done_d;
      timeout      <= to_d;
      cycle_count  <= cnt_d;
    end
  end

endmodule
